// File: rtl/prod_bcd_conv_if.sv
// Product-to-BCD handshake bundle between the multiplier and the BCD stage.
// The master side feeds products; the slave side returns decimal digits.
interface prod_bcd_conv_if #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
);
   logic                  in_valid;
   logic [WIDTH-1:0]      in_data;
   logic [4*DIGITS-1:0]   bcd_out;
   logic                  out_valid;
   logic                  busy;
   logic [2:0]            digit_count;

   modport master (
      output in_valid,
      output in_data,
      input  bcd_out,
      input  out_valid,
      input  busy,
      input  digit_count
   );

   modport slave (
      input  in_valid,
      input  in_data,
      output bcd_out,
      output out_valid,
      output busy,
      output digit_count
   );
endinterface

// File: rtl/prod_bcd_conv.sv
// Sequential double-dabble: converts one multiplier product to packed BCD,
// one bit per clock, and reports the count of significant digits.
module prod_bcd_conv #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
) (
   input  logic CLK,
   input  logic reset,
   prod_bcd_conv_if.slave bus
);
   localparam int BW = 4 * DIGITS;
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      CONVERT,
      DONE
   } state_t;

   state_t            state;
   logic              prev_valid;
   logic [WIDTH-1:0]  bin_sh;
   logic [BW-1:0]     bcd_sh;
   logic [CW-1:0]     bitcnt;
   logic [BW-1:0]     bcd_q;
   logic              out_valid_q;
   logic              busy_q;
   logic [2:0]        digit_count_q;

   logic [BW-1:0]     adj;
   logic [2:0]        nz_cnt;

   // Add-3 on every digit >=5 so the following shift carries correctly.
   always_comb begin
      adj = '0;
      for (int i = 0; i < DIGITS; i++) begin
         adj[4*i +: 4] = (bcd_sh[4*i +: 4] >= 4'd5) ?
                         bcd_sh[4*i +: 4] + 4'd3 :
                         bcd_sh[4*i +: 4];
      end
   end

   // Highest nonzero digit index + 1; zero still shows one digit.
   always_comb begin
      nz_cnt = 3'd1;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_sh[4*i +: 4] != 4'd0)
            nz_cnt = 3'(i + 1);
      end
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         prev_valid    <= 1'b0;
         bin_sh        <= '0;
         bcd_sh        <= '0;
         bitcnt        <= '0;
         bcd_q         <= '0;
         out_valid_q   <= 1'b0;
         busy_q        <= 1'b0;
         digit_count_q <= 3'd0;
      end else begin
         prev_valid <= bus.in_valid;
         unique case (state)
            IDLE: begin
               if (bus.in_valid && !prev_valid) begin
                  bin_sh      <= bus.in_data;
                  bcd_sh      <= '0;
                  bitcnt      <= '0;
                  busy_q      <= 1'b1;
                  out_valid_q <= 1'b0;
                  state       <= CONVERT;
               end
            end
            CONVERT: begin
               {bcd_sh, bin_sh} <= {adj[BW-2:0], bin_sh, 1'b0};
               bitcnt           <= bitcnt + 1'b1;
               if (bitcnt == LAST)
                  state <= DONE;
            end
            DONE: begin
               bcd_q         <= bcd_sh;
               digit_count_q <= nz_cnt;
               out_valid_q   <= 1'b1;
               busy_q        <= 1'b0;
               state         <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.bcd_out     = bcd_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.busy        = busy_q;
   assign bus.digit_count = digit_count_q;
endmodule

// File: tb/tb_prod_bcd_conv.sv
// Scoreboard bench for prod_bcd_conv: stimulus pushes expected results,
// a monitor pops them on every rising out_valid.
module tb_prod_bcd_conv;
   logic CLK = 1'b0;
   logic reset;

   prod_bcd_conv_if #(.WIDTH(16), .DIGITS(5)) bus ();

   prod_bcd_conv #(.WIDTH(16), .DIGITS(5)) dut (
      .CLK   (CLK),
      .reset (reset),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   int tests = 0;
   int fails = 0;
   logic [22:0] exp_q[$];
   logic stim_done = 1'b0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   task automatic start(input logic [15:0] d);
      @(negedge CLK);
      bus.in_data  = d;
      bus.in_valid = 1'b1;
   endtask

   // Waits for out_valid; checks it dropped and the old result is held.
   task automatic wait_done(input bit drop, input logic [19:0] held);
      int n;
      n = 0;
      do begin
         @(negedge CLK);
         n++;
         if (drop) bus.in_valid = 1'b0;
         if (n == 1) begin
            chk("ov_drop", 32'(bus.out_valid), 32'd0);
            chk("held", 32'(bus.bcd_out), 32'(held));
         end
      end while (!bus.out_valid && n < 40);
      chk("latency", n, 18);
   endtask

   task automatic push(input logic [19:0] b, input logic [2:0] c);
      exp_q.push_back({c, b});
   endtask

   // Monitor: result check on each rising out_valid, busy length check.
   initial begin
      logic prev_ov, prev_busy;
      int bcnt;
      logic [22:0] e;
      prev_ov = 1'b0;
      prev_busy = 1'b0;
      bcnt = 0;
      forever begin
         @(negedge CLK);
         if (bus.busy) bcnt++;
         if (prev_busy && !bus.busy && !reset)
            chk("busy_len", bcnt, 17);
         if (!bus.busy) bcnt = 0;
         if (!prev_ov && bus.out_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_result", 32'(bus.bcd_out), 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               chk("bcd_out", 32'(bus.bcd_out), 32'(e[19:0]));
               chk("digit_count", 32'(bus.digit_count), 32'(e[22:20]));
            end
         end
         prev_ov = bus.out_valid;
         prev_busy = bus.busy;
      end
   end

   initial begin
      reset = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data = '0;
      repeat (3) @(negedge CLK);
      chk("rst_bcd", 32'(bus.bcd_out), 32'd0);
      chk("rst_ov", 32'(bus.out_valid), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_cnt", 32'(bus.digit_count), 32'd0);
      reset = 1'b0;
      @(negedge CLK);

      push(20'h00027, 3'd2);
      start(16'd27);
      wait_done(1'b1, 20'h00000);

      push(20'h11211, 3'd5);
      start(16'd11211);
      wait_done(1'b1, 20'h00027);

      push(20'h65535, 3'd5);
      start(16'd65535);
      wait_done(1'b1, 20'h11211);

      push(20'h00000, 3'd1);
      start(16'd0);
      wait_done(1'b1, 20'h65535);
      chk("zero_ov", 32'(bus.out_valid), 32'd1);

      // in_valid held high, with a re-edge carrying 60 mid-conversion.
      push(20'h00140, 3'd3);
      start(16'd140);
      for (int i = 1; i <= 40; i++) begin
         @(negedge CLK);
         if (i == 4) bus.in_valid = 1'b0;
         if (i == 5) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'd60;
         end
      end
      chk("hold_bcd", 32'(bus.bcd_out), 32'h00140);
      chk("hold_busy", 32'(bus.busy), 32'd0);
      chk("hold_ov", 32'(bus.out_valid), 32'd1);
      bus.in_valid = 1'b0;
      @(negedge CLK);

      // Reset in the middle of a conversion of 861.
      start(16'd861);
      repeat (8) begin
         @(negedge CLK);
         bus.in_valid = 1'b0;
      end
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_bcd", 32'(bus.bcd_out), 32'd0);
      chk("mid_rst_ov", 32'(bus.out_valid), 32'd0);
      chk("mid_rst_busy", 32'(bus.busy), 32'd0);
      chk("mid_rst_cnt", 32'(bus.digit_count), 32'd0);
      repeat (2) @(negedge CLK);
      reset = 1'b0;
      @(negedge CLK);
      push(20'h00861, 3'd3);
      start(16'd861);
      wait_done(1'b1, 20'h00000);

      // Back-to-back: 140 held high, one low cycle, then 60.
      push(20'h00140, 3'd3);
      start(16'd140);
      wait_done(1'b0, 20'h00861);
      @(negedge CLK);
      bus.in_valid = 1'b0;
      push(20'h00060, 3'd2);
      start(16'd60);
      wait_done(1'b1, 20'h00140);

      repeat (5) @(negedge CLK);
      chk("queue_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL timeout: got running, expected finished");
      $fatal(1, "timeout");
   end
endmodule
